// File: rtl/sticky_sr_status.sv
// Sticky per-bit set/clear status register with IRQ/popcount summaries and a serial snapshot readout.
// Optional read-to-clear on readout completion: define STICKY_SR_RD_CLEAR_EN.
module sticky_sr_status #(
  parameter int WIDTH        = 8,
  parameter int SET_POLARITY = 1,
  parameter int CLR_POLARITY = 1
) (
  input  logic                       CLK,
  input  logic                       SRST,
  input  logic [WIDTH-1:0]           SET,
  input  logic [WIDTH-1:0]           CLR,
  output logic [WIDTH-1:0]           Q,
  output logic                       IRQ,
  output logic [$clog2(WIDTH+1)-1:0] PENDING,
  input  logic                       RD_REQ,
  output logic                       RD_BUSY,
  output logic                       RD_VALID,
  output logic                       RD_BIT,
  output logic                       RD_LAST,
  input  logic                       RD_READY
);

  localparam int PW    = $clog2(WIDTH + 1);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} rd_state_e;

  rd_state_e        state_q, state_d;
  logic [WIDTH-1:0] q_p0, snap_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             irq_p0;
  logic [PW-1:0]    pend_p1;

  logic [WIDTH-1:0] set_act, clr_act, rtc_mask, q_nxt, snap_sh;
  logic             beat_last, beat_xfer;

  function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  assign set_act = (SET_POLARITY != 0) ? SET : ~SET;
  assign clr_act = (CLR_POLARITY != 0) ? CLR : ~CLR;

`ifdef STICKY_SR_RD_CLEAR_EN
  // Only bits captured in the snapshot are eligible, so late sets survive.
  assign rtc_mask = (state_q == DONE) ? snap_p0 : '0;
`else
  assign rtc_mask = '0;
`endif

  // Priority: clear, then set, then read-to-clear, then hold.
  assign q_nxt     = ~clr_act & (set_act | (q_p0 & ~rtc_mask));
  assign snap_sh   = snap_p0 >> idx_p0;
  assign beat_last = (idx_p0 == LAST_IDX);
  assign beat_xfer = (state_q == SHIFT) && RD_READY;

  always_comb begin
    state_d  = state_q;
    RD_BUSY  = 1'b0;
    RD_VALID = 1'b0;
    RD_BIT   = 1'b0;
    RD_LAST  = 1'b0;
    case (state_q)
      IDLE:  if (RD_REQ) state_d = SHIFT;
      SHIFT: begin
        RD_BUSY  = 1'b1;
        RD_VALID = 1'b1;
        RD_BIT   = snap_sh[0];
        RD_LAST  = beat_last;
        if (beat_xfer && beat_last) state_d = DONE;
      end
      DONE: begin
        RD_BUSY = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: status bits, IRQ and readout control
  always_ff @(posedge CLK) begin
    if (SRST) begin
      state_q <= IDLE;
      q_p0    <= '0;
      irq_p0  <= 1'b0;
      snap_p0 <= '0;
      idx_p0  <= '0;
    end else begin
      state_q <= state_d;
      q_p0    <= q_nxt;
      irq_p0  <= |q_nxt;
      if (state_q == IDLE && RD_REQ) begin
        snap_p0 <= q_p0;
        idx_p0  <= '0;
      end else if (beat_xfer && !beat_last) begin
        idx_p0  <= idx_p0 + IDX_W'(1);
      end
    end
  end

  // Stage p1: popcount of the registered status
  always_ff @(posedge CLK) begin
    if (SRST) pend_p1 <= '0;
    else      pend_p1 <= popcount(q_p0);
  end

  assign Q       = q_p0;
  assign IRQ     = irq_p0;
  assign PENDING = pend_p1;

endmodule

// File: tb/tb_sticky_sr_status.sv
// Directed and randomized bench for sticky_sr_status against a queue-based reference model.
module tb_sticky_sr_status;

`ifdef STICKY_SR_RD_CLEAR_EN
  localparam bit RDC = 1'b1;
`else
  localparam bit RDC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [7:0] set_r = '0, clr_r = '0;
  logic       rd_req = 1'b0, rd_ready = 1'b0;
  logic [7:0] q;
  logic       irq, rd_busy, rd_valid, rd_bit, rd_last;
  logic [3:0] pend;

  logic set1 = 1'b1, clr1 = 1'b1, rd_req1 = 1'b0, rd_ready1 = 1'b0;
  logic q1, irq1, pend1, rd_busy1, rd_valid1, rd_bit1, rd_last1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sticky_sr_status #(.WIDTH(8), .SET_POLARITY(1), .CLR_POLARITY(1)) dut (
    .CLK(clk), .SRST(srst), .SET(set_r), .CLR(clr_r), .Q(q), .IRQ(irq), .PENDING(pend),
    .RD_REQ(rd_req), .RD_BUSY(rd_busy), .RD_VALID(rd_valid), .RD_BIT(rd_bit),
    .RD_LAST(rd_last), .RD_READY(rd_ready)
  );

  sticky_sr_status #(.WIDTH(1), .SET_POLARITY(0), .CLR_POLARITY(0)) dut1 (
    .CLK(clk), .SRST(srst), .SET(set1), .CLR(clr1), .Q(q1), .IRQ(irq1), .PENDING(pend1),
    .RD_REQ(rd_req1), .RD_BUSY(rd_busy1), .RD_VALID(rd_valid1), .RD_BIT(rd_bit1),
    .RD_LAST(rd_last1), .RD_READY(rd_ready1)
  );

  // Reference model: status byte, pending count, and the remaining snapshot bits as a queue.
  logic [7:0] mq = '0, msnap = '0;
  bit         mirq = 1'b0, mshift = 1'b0, mdone = 1'b0;
  int         mpend = 0;
  bit         mbits[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [7:0] old, nq;
    if (srst) begin
      mq = '0; msnap = '0; mirq = 1'b0; mpend = 0;
      mshift = 1'b0; mdone = 1'b0; mbits.delete();
    end else begin
      old = mq;
      for (int i = 0; i < 8; i++) begin
        if (clr_r[i])                     nq[i] = 1'b0;
        else if (set_r[i])                nq[i] = 1'b1;
        else if (RDC && mdone && msnap[i]) nq[i] = 1'b0;
        else                              nq[i] = old[i];
      end
      mq    = nq;
      mirq  = (nq != 0);
      mpend = $countones(old);
      if (mdone) mdone = 1'b0;
      else if (mshift) begin
        if (rd_ready) begin
          void'(mbits.pop_front());
          if (mbits.size() == 0) begin mshift = 1'b0; mdone = 1'b1; end
        end
      end else if (rd_req) begin
        msnap = old;
        for (int i = 0; i < 8; i++) mbits.push_back(old[i]);
        mshift = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("q", q, mq);
    chk("irq", irq, mirq);
    chk("pending", pend, mpend);
    chk("rd_busy", rd_busy, mshift || mdone);
    chk("rd_valid", rd_valid, mshift);
    chk("rd_bit", rd_bit, mshift ? mbits[0] : 1'b0);
    chk("rd_last", rd_last, mshift && (mbits.size() == 1));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int nb, nlast, last_at;

    // Reset state
    step(); step();
    srst = 1'b0;
    chk("rst_q", q, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_pend", pend, 4'd0);
    chk("rst_busy", rd_busy, 1'b0);
    chk("rst_q1", q1, 1'b0);

    // Clear beats set in the same cycle
    set_r = 8'hFF; clr_r = 8'h0F; step();
    chk("prio_q", q, 8'hF0);
    chk("prio_irq", irq, 1'b1);
    set_r = '0; clr_r = '0; step();
    chk("prio_pend", pend, 4'd4);

    // Readout of 0xA5 with toggling backpressure
    srst = 1'b1; step(); srst = 1'b0;
    set_r = 8'hA5; step(); set_r = '0;
    rd_req = 1'b1; step(); rd_req = 1'b0;
    rd_ready = 1'b1; nb = 0; nlast = 0; last_at = -1; got = '0;
    for (int k = 0; k < 40 && !mdone; k++) begin
      if (rd_ready && rd_valid) begin
        if (nb < 8) got[nb] = rd_bit;
        if (rd_last) begin nlast++; last_at = nb; end
        nb++;
      end
      step();
      rd_ready = ~rd_ready;
    end
    chk("bp_reached_done", mdone, 1'b1);
    chk("bp_beats", nb, 8);
    chk("bp_bits", got, 8'hA5);
    chk("bp_last_cnt", nlast, 1);
    chk("bp_last_pos", last_at, 7);
    chk("bp_done_busy", rd_busy, 1'b1);
    chk("bp_done_valid", rd_valid, 1'b0);
    rd_ready = 1'b0; step();
    chk("bp_rtc_q", q, RDC ? 8'h00 : 8'hA5);
    chk("bp_idle_busy", rd_busy, 1'b0);

    // Read-to-clear race with late set and set during DONE
    srst = 1'b1; step(); srst = 1'b0;
    set_r = 8'h01; step(); set_r = '0;
    rd_req = 1'b1; rd_ready = 1'b1; step(); rd_req = 1'b0;
    step(); step();
    set_r = 8'h80; step(); set_r = '0;
    for (int k = 0; k < 20 && !mdone; k++) step();
    chk("race_reached_done", mdone, 1'b1);
    set_r = 8'h01; step(); set_r = '0;
    chk("race_q", q, 8'h81);

    // Reset during beat 3, then a fresh readout starts at bit 0
    rd_ready = 1'b0;
    srst = 1'b1; step(); srst = 1'b0;
    set_r = 8'h3C; step(); set_r = '0;
    rd_req = 1'b1; rd_ready = 1'b1; step(); rd_req = 1'b0;
    step(); step();
    srst = 1'b1; step(); srst = 1'b0; rd_ready = 1'b0;
    chk("abort_q", q, 8'h00);
    chk("abort_busy", rd_busy, 1'b0);
    chk("abort_valid", rd_valid, 1'b0);
    chk("abort_last", rd_last, 1'b0);
    set_r = 8'h02; step(); set_r = '0;
    rd_req = 1'b1; step(); rd_req = 1'b0;
    chk("fresh_bit0", rd_bit, 1'b0);
    chk("fresh_valid", rd_valid, 1'b1);
    rd_ready = 1'b1; step();
    chk("fresh_bit1", rd_bit, 1'b1);
    for (int k = 0; k < 20 && (mshift || mdone); k++) step();
    rd_ready = 1'b0;

    // WIDTH=1 instance with active-low set/clear
    set1 = 1'b0; step(); set1 = 1'b1;
    chk("w1_set_q", q1, 1'b1);
    rd_req1 = 1'b1; step(); rd_req1 = 1'b0;
    chk("w1_valid", rd_valid1, 1'b1);
    chk("w1_bit", rd_bit1, 1'b1);
    chk("w1_last", rd_last1, 1'b1);
    rd_ready1 = 1'b1; step(); rd_ready1 = 1'b0;
    chk("w1_done_busy", rd_busy1, 1'b1);
    chk("w1_done_valid", rd_valid1, 1'b0);
    step();
    chk("w1_idle_busy", rd_busy1, 1'b0);
    chk("w1_rtc_q", q1, RDC ? 1'b0 : 1'b1);
    clr1 = 1'b0; step(); clr1 = 1'b1;
    chk("w1_clr_q", q1, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      set_r    = 8'($urandom) & 8'($urandom);
      clr_r    = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rd_req   = ($urandom_range(0, 3) == 0);
      rd_ready = $urandom_range(0, 1) == 1;
      srst     = ($urandom_range(0, 63) == 0);
      step();
    end
    srst = 1'b0; set_r = '0; clr_r = '0; rd_req = 1'b0; rd_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sticky_sr_status.md
# sticky_sr_status

Sticky per-bit status register for `$dffsr`-style set/clear request vectors. Bit behaviour:
- Clear has priority over set.
- A bit holds its value otherwise.

The block produces the vectors that, after mapping, become plain-DFF set/clear logic. It is fully synchronous and adds three features: a serial readout engine, read-to-clear, and summary outputs (any-set flag, popcount) for a downstream status/interrupt consumer.

## Interface
- `WIDTH`, 8, number of status bits (1..64)
- `SET_POLARITY`, 1, active level of each `SET` bit
- `CLR_POLARITY`, 1, active level of each `CLR` bit

- `CLK`  in  1  clock; all state updates on posedge
- `SRST`  in  1  reset; synchronous, active-high
- `SET`  in  WIDTH  per-bit set request
- `CLR`  in  WIDTH  per-bit clear request
- `Q`  out  WIDTH  sticky status bits
- `IRQ`  out  1  high when any `Q` bit is 1
- `PENDING`  out  $clog2(WIDTH+1)  popcount of `Q`
- `RD_REQ`  in  1  start serial readout
- `RD_BUSY`  out  1  readout in progress (states SHIFT or DONE)
- `RD_VALID`  out  1  `RD_BIT` is valid
- `RD_BIT`  out  1  current snapshot bit, LSB first
- `RD_LAST`  out  1  current beat is bit WIDTH-1
- `RD_READY`  in  1  consumer accepts the beat

## Operation
- Per bit `i`, the next value of `Q[i]` is chosen in this priority order:
  1. `CLR[i]==CLR_POLARITY` → 0.
  2. `SET[i]==SET_POLARITY` → 1.
  3. Read-to-clear applies (DONE state, `snap[i]==1`) → 0.
  4. Otherwise `Q[i]` holds.
- `IRQ` is a register loaded with the OR-reduction of next-`Q`, so it is cycle-aligned with `Q`.
- `PENDING` is a register loaded with the popcount of the current `Q`. It is combinationally independent of `SET`/`CLR`.
- Readout FSM states: IDLE, SHIFT, DONE.
  - IDLE: `RD_REQ`=1 → copy `Q` into `snap`, set `idx`=0, go to SHIFT.
  - SHIFT:
    - Outputs: `RD_VALID`=1, `RD_BIT`=`snap[idx]`, `RD_LAST`=(`idx`==WIDTH-1).
    - A beat transfers when `RD_VALID & RD_READY`. Otherwise all outputs hold.
    - On a transfer with `RD_LAST` → go to DONE. Any other transfer → `idx`+1.
  - DONE: lasts exactly one cycle with `RD_VALID`=0. Applies read-to-clear, then goes to IDLE.
- `RD_REQ` is ignored outside IDLE; there is no queuing.
- `snap` is frozen for the whole readout. `SET`/`CLR` during SHIFT change `Q` but not the bits being shifted out.
- A bit set after the snapshot is taken is never cleared by read-to-clear, because read-to-clear only touches bits that are 1 in `snap`.
- WIDTH=1: a single beat with `RD_LAST`=1.

## Timing
- Reset values: `Q`=0, `IRQ`=0, `PENDING`=0, `RD_BUSY`=0, `RD_VALID`=0, `RD_BIT`=0, `RD_LAST`=0, FSM=IDLE, `idx`=0, `snap`=0.
- `SRST` overrides `SET`/`CLR` in the same cycle.
- `SRST` during SHIFT or DONE aborts the readout. No read-to-clear is applied, and the reset values appear in the next cycle.
- Latencies, for a set/clear sampled at edge N:
  - `Q` and `IRQ` reflect it after edge N.
  - `PENDING` reflects it after edge N+1.
- Readout cycle numbering:
  - `RD_REQ` sampled at edge N → `RD_VALID`/`RD_BUSY` high after N.
  - `snap` is the `Q` value visible before edge N.
  - Minimum readout is WIDTH beats plus 1 DONE cycle.
  - Last beat accepted at edge M → DONE after M → read-to-clear visible in `Q` and IDLE entered after M+1.
  - A new `RD_REQ` is accepted at edge M+2 at the earliest.
- Simultaneous events in DONE, per bit: `SET` keeps the bit at 1, and `CLR` clears it regardless of `snap`.

## Configuration
- Macro: `STICKY_SR_RD_CLEAR_EN`.
  - Defined: DONE applies read-to-clear as described above.
  - Undefined: DONE is a one-cycle no-op; `Q` is changed only by `SET`/`CLR`/`SRST`.
- FSM sequencing and timing are identical in both builds.

## Test plan
All scenarios use WIDTH=8 unless stated otherwise.
- Set/clear priority: `SET`=0xFF and `CLR`=0x0F in the same cycle → `Q`=0xF0 after 1 edge, `IRQ`=1, `PENDING`=4 one edge later.
- Readout with backpressure:
  - Setup: `Q`=0xA5, pulse `RD_REQ`, `RD_READY` toggled 1/0 each cycle.
  - Expect accepted bits 1,0,1,0,0,1,0,1 and `RD_LAST` only on the 8th beat.
  - With `RD_CLEAR_EN` defined, `Q`=0x00 two edges after the last beat.
- Read-to-clear race:
  - Setup: `Q`=0x01 at snapshot; `SET[7]` pulsed mid-SHIFT; `SET[0]` held high during DONE.
  - Expect `Q`=0x81 after DONE: bit 0 survives because `SET` wins, and bit 7 is untouched because it is not in `snap`.
- Reset mid-readout: `SRST` during beat 3 → next cycle all outputs at reset values, FSM IDLE, and a fresh `RD_REQ` starts from `idx`=0.
- Polarity and width: WIDTH=1, `SET_POLARITY`=0, `CLR_POLARITY`=0.
  - `SET`=0 → `Q`=1.
  - Readout gives one beat with `RD_BIT`=1 and `RD_LAST`=1.
  - `CLR`=0 → `Q`=0.
- Macro undefined: repeat the readout scenario → `Q` stays 0xA5 after DONE, and DONE still lasts 1 cycle.
